// File: rtl/bus_arb2.sv
// bus_arb2 -- two-master arbiter for the shared valid/ready memory bus.
//
// Purpose:
//   Lets two cores share one slave port. In IDLE a winner is chosen among
//   the requesting masters and its request is latched into the slave-side
//   registers. In BUSY the latched request is held until the slave answers,
//   and that answer is routed to the granted master only.
//
// Configuration:
//   BUS_ARB2_RR_EN  defined   -> round-robin between the masters on ties.
//                   undefined -> fixed priority; master 0 wins ties.
//
// Ports:
//   clk, rstb               clock, asynchronous active-low reset
//   m0_* / m1_*             master request (valid/write/size/addr/wdata)
//                           and completion (ready/rdata)
//   s_valid/s_write/s_size/s_addr/s_wdata   registered request to slave
//   s_ready, s_rdata        slave completion and read data
//   gnt                     one-hot grant, 00 when idle
//   busy                    high while a transaction is outstanding
module bus_arb2 #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rstb,

    input  logic          m0_valid,
    input  logic          m0_write,
    input  logic [2:0]    m0_size,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ready,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_valid,
    input  logic          m1_write,
    input  logic [2:0]    m1_size,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ready,
    output logic [DW-1:0] m1_rdata,

    output logic          s_valid,
    output logic          s_write,
    output logic [2:0]    s_size,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic          s_ready,
    input  logic [DW-1:0] s_rdata,

    output logic [1:0]    gnt,
    output logic          busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state;
    logic   win1;   // master 1 wins the current arbitration

`ifdef BUS_ARB2_RR_EN
    // prio1 set means master 1 is favoured on the next tie; it flips to the
    // master that was not just granted, so the reset value favours master 0.
    logic prio1;
    assign win1 = m1_valid & (~m0_valid | prio1);
`else
    assign win1 = m1_valid & ~m0_valid;
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state   <= IDLE;
            s_valid <= 1'b0;
            s_write <= 1'b0;
            s_size  <= '0;
            s_addr  <= '0;
            s_wdata <= '0;
            gnt     <= 2'b00;
`ifdef BUS_ARB2_RR_EN
            prio1   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (m0_valid | m1_valid) begin
                        state   <= BUSY;
                        s_valid <= 1'b1;
                        gnt     <= win1 ? 2'b10 : 2'b01;
                        s_write <= win1 ? m1_write : m0_write;
                        s_size  <= win1 ? m1_size  : m0_size;
                        s_addr  <= win1 ? m1_addr  : m0_addr;
                        s_wdata <= win1 ? m1_wdata : m0_wdata;
`ifdef BUS_ARB2_RR_EN
                        prio1   <= ~win1;
`endif
                    end
                end
                BUSY: begin
                    // Request registers stay untouched so s_* are stable
                    // for the whole slave transaction.
                    if (s_ready) begin
                        state   <= IDLE;
                        s_valid <= 1'b0;
                        gnt     <= 2'b00;
                    end
                end
                default: begin
                    state   <= IDLE;
                    s_valid <= 1'b0;
                    gnt     <= 2'b00;
                end
            endcase
        end
    end

    assign busy = (state == BUSY);

    // Completion goes only to the granted master; s_ready seen in IDLE
    // is dropped here because busy is low.
    assign m0_ready = s_ready & busy & gnt[0];
    assign m1_ready = s_ready & busy & gnt[1];

    // Read data is shared; ready is the qualifier.
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;

endmodule
